// File: rtl/adder8_operand_feeder.sv
// adder8_operand_feeder: pairs consecutive input bytes (A then B) into a 2-entry operand FIFO for the adder.
// Latency: a pair pushed at edge N is visible on op_a/op_b/op_valid in the cycle after edge N; no bypass path.
// Backpressure: in_ready drops only while waiting for B with the FIFO full and no pop in the same cycle.
//
// Ports:
//   clk, rst                  system clock; asynchronous active-high reset
//   in_data/in_valid/in_ready operand byte stream from ui_in
//   op_a/op_b/op_valid/op_ready  FIFO head pair towards the adder
//   fifo_level                pairs buffered (0..2)
//   pair_count                pairs pushed since reset, wraps at 256
//   timeout_err               one-cycle pulse when a lone A is discarded
// Optional feature: define ADDER8_FEEDER_TIMEOUT_EN to discard an A that waits
// TIMEOUT_CYCLES cycles for its B. Without it, WAIT_B waits forever and
// timeout_err is tied low.

module adder8_operand_feeder #(
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [1:0] fifo_level,
  output logic [7:0] pair_count,
  output logic       timeout_err
);

  typedef enum logic {WAIT_A = 1'b0, WAIT_B = 1'b1} phase_t;

  localparam logic [1:0] FULL_LEVEL = 2'(FIFO_DEPTH);

  // Catch an out-of-range timeout at elaboration time.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("adder8_operand_feeder: TIMEOUT_CYCLES must be 1..255");
  end

  phase_t     phase;
  logic [7:0] a_reg;
  logic [7:0] slot_a [2];
  logic [7:0] slot_b [2];
  logic       rd_ptr;
  logic [1:0] level;

  logic       pop;
  logic       xfer;
  logic       push;
  logic       wr_idx;
  logic       expire;

  assign op_valid   = (level != 2'd0);
  assign fifo_level = level;
  assign op_a       = op_valid ? slot_a[rd_ptr] : 8'd0;
  assign op_b       = op_valid ? slot_b[rd_ptr] : 8'd0;

  assign pop      = op_valid && op_ready;
  // A full FIFO can still take B when the head leaves in the same cycle.
  assign in_ready = (phase == WAIT_A) || (level != FULL_LEVEL) || pop;
  assign xfer     = in_valid && in_ready;
  assign push     = xfer && (phase == WAIT_B);
  // Tail slot: rd_ptr+level mod 2. At level 2 with a pop this lands on the freed head slot.
  assign wr_idx   = rd_ptr ^ level[0];

`ifdef ADDER8_FEEDER_TIMEOUT_EN
  logic [7:0] tcnt;

  // A B transfer in the expiry cycle wins, hence the !xfer term.
  assign expire = (phase == WAIT_B) && !xfer && (tcnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt        <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
      if (phase == WAIT_A || xfer || expire) begin
        tcnt <= 8'd0;
      end else begin
        tcnt <= tcnt + 8'd1;
      end
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= WAIT_A;
      a_reg      <= 8'd0;
      slot_a[0]  <= 8'd0;
      slot_a[1]  <= 8'd0;
      slot_b[0]  <= 8'd0;
      slot_b[1]  <= 8'd0;
      rd_ptr     <= 1'b0;
      level      <= 2'd0;
      pair_count <= 8'd0;
    end else begin
      case (phase)
        WAIT_A: begin
          if (xfer) begin
            a_reg <= in_data;
            phase <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (xfer || expire) begin
            phase <= WAIT_A;
          end
        end
        default: phase <= WAIT_A;
      endcase

      if (push) begin
        slot_a[wr_idx] <= a_reg;
        slot_b[wr_idx] <= in_data;
        pair_count     <= pair_count + 8'd1;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      if (push && !pop) begin
        level <= level + 2'd1;
      end else if (pop && !push) begin
        level <= level - 2'd1;
      end
    end
  end

endmodule

// File: doc/adder8_operand_feeder.md
Name: adder8_operand_feeder

Overview:
- Upstream stage of the 8-bit adder user project.
- Collects a byte stream from the dedicated input pins and pairs consecutive bytes as operands A then B.
- Buffers complete pairs in a 2-entry FIFO and presents them to the adder with a valid/ready handshake.
- Keeps a wrapping count of issued pairs, which can be muxed onto uio_out.

Parameters:
- FIFO_DEPTH, 2, number of buffered operand pairs; fixed at 2, level width 2 bits.
- TIMEOUT_CYCLES, 16, cycles allowed between A capture and B capture; used only with the optional feature; legal range 1..255.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  8  operand byte from ui_in
- in_valid  input  1  in_data valid
- in_ready  output  1  feeder accepts in_data this cycle
- op_a  output  8  operand A of FIFO head
- op_b  output  8  operand B of FIFO head
- op_valid  output  1  FIFO head holds a valid pair
- op_ready  input  1  adder consumes head this cycle
- fifo_level  output  2  pairs buffered, 0..2
- pair_count  output  8  pairs pushed since reset, wraps 255->0
- timeout_err  output  1  one-cycle pulse when a lone A is discarded

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Port names are clk and rst.
- Reset state:
  - phase=WAIT_A, A holding register=0, FIFO empty.
  - op_a=0, op_b=0, op_valid=0, fifo_level=0.
  - pair_count=0, timeout_err=0, timeout counter=0.
- Input handshake:
  - A byte transfers when in_valid and in_ready are both high.
  - in_ready is combinational:
    - WAIT_A: 1.
    - WAIT_B: 1 if fifo_level<2, or if fifo_level==2 and a pop occurs in the same cycle.
- Phase FSM, two states:
  - WAIT_A: on transfer, latch in_data into the A register and go to WAIT_B.
  - WAIT_B: on transfer, push {A, in_data} into the FIFO, increment pair_count, go to WAIT_A.
- Output handshake:
  - op_valid = (fifo_level!=0).
  - op_a/op_b show the head entry combinationally; both are 0 when the FIFO is empty.
  - Pop on op_valid && op_ready.
  - op_a/op_b must stay stable while op_valid=1 and op_ready=0.
- Simultaneous push and pop: the level is unchanged and ordering is preserved. At level 2 the new pair enters the freed slot.
- Pop when empty: no effect. Push when full: impossible by construction.
- Latency:
  - A pair pushed at edge N has op_valid=1 in the cycle after edge N if the FIFO was empty.
  - There is no bypass from in_data to op_a/op_b.
- pair_count is modulo 256 and counts pushes, not pops.
- Reset asserted mid-operation: the pending A, all FIFO contents and the timeout counter are discarded immediately. Nothing partial is emitted after rst deasserts.

Optional Feature:
- Macro: ADDER8_FEEDER_TIMEOUT_EN.
- Defined:
  - The timeout counter clears on A capture and increments each cycle in WAIT_B without a B transfer.
  - When it reaches TIMEOUT_CYCLES, the pending A is discarded, phase returns to WAIT_A, and timeout_err=1 for exactly one cycle.
  - A B transfer in the same cycle the counter would expire wins: the pair is pushed and there is no error.
  - A stalled in_ready (FIFO full) still counts toward the timeout.
- Not defined:
  - timeout_err is tied 0 and no counter is instantiated.
  - WAIT_B waits indefinitely.

Test Plan:
- Reset, then send bytes 0x12, 0x34 with op_ready=1 -> op_valid=1 with op_a=0x12, op_b=0x34 for one cycle; pair_count=1; fifo_level returns to 0.
- op_ready=0, stream 0x01,0x02,0x03,0x04,0x05,0x06 -> fifo_level=2 after 4 bytes; in_ready=0 when 0x06 is offered; head stays 0x01/0x02. Then raise op_ready for one cycle -> 0x06 accepted in that cycle, level stays 2, pairs pop in order.
- Capture A=0xAA, then assert rst for 1 cycle -> all outputs 0. Next bytes 0x05, 0x07 -> pair 0x05/0x07 with no trace of 0xAA.
- Push 256 pairs while consuming -> pair_count wraps to 0x00 after pair 256.
- With macro defined and TIMEOUT_CYCLES=4: A=0x11, then idle -> timeout_err pulses once on the 4th cycle. Next bytes 0x22, 0x33 -> pair 0x22/0x33. Repeat with B sent on the expiry cycle -> pair pushed, no pulse.
- Without the macro: A=0x11, idle 1000 cycles, then B=0x44 -> pair 0x11/0x44 and timeout_err never asserts.
